// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and oversampling constants.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StData  = 2'b10,
    StStop  = 2'b11
  } state_e;

  // 16x oversampling; the start bit is confirmed at its middle (tick index 7).
  localparam int unsigned OVS = 16;
  localparam int unsigned MID = 7;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a selectable reset value.
module uart_rx_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver timed by a 16x oversampling tick; delivers each byte with a done strobe
// and a framing-error flag.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            RX,
  input  logic            S_TICK,
  output logic [DBIT-1:0] DOUT,
  output logic            RX_DONE_TICK,
  output logic            FRAME_ERR
);

  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [3:0]    S_MID  = 4'(MID);
  localparam logic [3:0]    S_LAST = 4'(OVS - 1);
  localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic w_rx_s;

  state_e          r_state, w_state_d;
  logic [3:0]      r_s, w_s_d;
  logic [NW-1:0]   r_n, w_n_d;
  logic [DBIT-1:0] r_b, w_b_d;
  logic [DBIT-1:0] r_dout, w_dout_d;
  logic            r_done, w_done_d;
  logic            r_ferr, w_ferr_d;

  uart_rx_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_d     (RX),
    .o_q     (w_rx_s)
  );

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= StIdle;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_s     <= w_s_d;
      r_n     <= w_n_d;
      r_b     <= w_b_d;
      r_dout  <= w_dout_d;
      r_done  <= w_done_d;
      r_ferr  <= w_ferr_d;
    end
  end

  // Next-state logic: every state except IDLE advances only on S_TICK.
  always_comb begin
    w_state_d = r_state;
    w_s_d     = r_s;
    w_n_d     = r_n;
    w_b_d     = r_b;
    w_dout_d  = r_dout;
    w_ferr_d  = r_ferr;
    w_done_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        // A tick coinciding with start detection is deliberately not counted.
        if (!w_rx_s) begin
          w_state_d = StStart;
          w_s_d     = '0;
        end
      end
      StStart: begin
        if (S_TICK) begin
          if (r_s == S_MID) begin
            if (!w_rx_s) begin
              w_state_d = StData;
              w_s_d     = '0;
              w_n_d     = '0;
            end else begin
              // Line went back high by mid-start-bit: treat as noise.
              w_state_d = StIdle;
            end
          end else begin
            w_s_d = r_s + 4'd1;
          end
        end
      end
      StData: begin
        if (S_TICK) begin
          if (r_s == S_LAST) begin
            w_s_d = '0;
            w_b_d = {w_rx_s, r_b[DBIT-1:1]};
            if (r_n == N_LAST) begin
              w_state_d = StStop;
            end else begin
              w_n_d = r_n + 1'b1;
            end
          end else begin
            w_s_d = r_s + 4'd1;
          end
        end
      end
      StStop: begin
        if (S_TICK) begin
          if (r_s == S_STOP) begin
            // Frames with a bad stop bit are still delivered, flagged by FRAME_ERR.
            w_dout_d  = r_b;
            w_ferr_d  = ~w_rx_s;
            w_done_d  = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_s_d = r_s + 4'd1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign DOUT         = r_dout;
  assign RX_DONE_TICK = r_done;
  assign FRAME_ERR    = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the stimulus pushes expected frames, a monitor checks each done.
module tb_uart_rx;

  logic       CLK;
  logic       RESET;
  logic       RX;
  logic       S_TICK;
  logic [7:0] DOUT;
  logic       RX_DONE_TICK;
  logic       FRAME_ERR;

  typedef struct {
    logic [7:0] dout;
    logic       ferr;
    bit         timed;
    int         start_tick;
  } exp_t;

  exp_t exp_q[$];

  int  checks    = 0;
  int  errors    = 0;
  int  tick_cnt  = 0;
  int  div       = 0;
  bit  tick_en   = 1'b0;

  uart_rx #(
    .DBIT    (8),
    .SB_TICK (16)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .RX           (RX),
    .S_TICK       (S_TICK),
    .DOUT         (DOUT),
    .RX_DONE_TICK (RX_DONE_TICK),
    .FRAME_ERR    (FRAME_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One-CLK tick every 4 clocks, changed on the falling edge.
  initial begin
    S_TICK = 1'b0;
    forever begin
      @(negedge CLK);
      div    = (div + 1) % 4;
      S_TICK = tick_en && (div == 0);
      if (S_TICK) tick_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected frame.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (RX_DONE_TICK) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got dout=%0h expected no done", DOUT);
        end else begin
          e = exp_q.pop_front();
          check("dout", 32'(DOUT), 32'(e.dout));
          check("frame_err", 32'(FRAME_ERR), 32'(e.ferr));
          if (e.timed) check("latency_ticks", 32'(tick_cnt - e.start_tick), 32'd152);
        end
      end
    end
  end

  // Returns 1 ns after the rising edge that sampled a tick.
  task automatic wait_tick();
    int guard = 0;
    @(posedge CLK);
    while (!S_TICK) begin
      guard++;
      if (guard > 100) begin
        $display("FAIL tick_timeout: got no tick expected tick within 100 clk");
        $fatal(1);
      end
      @(posedge CLK);
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) wait_tick();
  endtask

  // Sends one frame tick by tick; hold_tick pauses ticks, reset_tick aborts with a reset pulse.
  task automatic send_frame(input logic [7:0] data, input logic stop_val, input bit timed,
                            input int hold_tick, input int reset_tick);
    exp_t e;
    if (reset_tick == 0) begin
      e.dout       = data;
      e.ferr       = ~stop_val;
      e.timed      = timed;
      e.start_tick = tick_cnt;
      exp_q.push_back(e);
    end
    RX = 1'b0;
    for (int t = 1; t <= 160; t++) begin
      wait_tick();
      if (t == hold_tick) begin
        tick_en = 1'b0;
        repeat (1000) @(posedge CLK);
        #1;
        check("hold_state", 32'(dut.r_state), 32'd2);
        check("hold_s", 32'(dut.r_s), 32'd5);
        check("hold_n", 32'(dut.r_n), 32'd3);
        tick_en = 1'b1;
      end
      if (t == reset_tick) begin
        RESET = 1'b0;
        RX    = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_dout", 32'(DOUT), 32'd0);
        check("rst_ferr", 32'(FRAME_ERR), 32'd0);
        check("rst_done", 32'(RX_DONE_TICK), 32'd0);
        RESET = 1'b1;
        return;
      end
      if (t < 144 && (t % 16) == 0) RX = data[t/16-1];
      else if (t == 144) RX = stop_val;
      else if (t == 152) RX = 1'b1;
    end
  endtask

  initial begin
    RESET = 1'b0;
    RX    = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_dout", 32'(DOUT), 32'd0);
    check("reset_done", 32'(RX_DONE_TICK), 32'd0);
    check("reset_ferr", 32'(FRAME_ERR), 32'd0);
    RESET   = 1'b1;
    tick_en = 1'b1;
    idle(4);

    // Short low pulse: rejected at mid-start-bit, no output.
    RX = 1'b0;
    idle(4);
    RX = 1'b1;
    idle(20);
    check("glitch_dout", 32'(DOUT), 32'd0);

    send_frame(8'h55, 1'b1, 1'b1, 0, 0);
    idle(20);
    send_frame(8'hA3, 1'b0, 1'b0, 0, 0);
    idle(20);
    send_frame(8'h3C, 1'b1, 1'b0, 0, 0);
    idle(20);

    // Reset during data bit 3 (ticks 64..79 of the frame).
    send_frame(8'hFF, 1'b1, 1'b0, 0, 70);
    idle(20);
    send_frame(8'h0F, 1'b1, 1'b0, 0, 0);
    idle(20);

    send_frame(8'h00, 1'b1, 1'b0, 0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 0, 0);
    idle(20);

    // Tick 61 lands in data bit 3 with s=5.
    send_frame(8'h96, 1'b1, 1'b0, 61, 0);
    idle(20);

    check("frames_pending", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
